// File: rtl/cache_tag_array_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared types, default geometry and tree pseudo-LRU helpers for the
// cache_tag_array slice.
//
// The PLRU helpers work on a 7-bit node vector, which is enough for 8 ways.
// Way numbers are 3 bits wide and MSB-aligned, so that way bit 2 selects the
// root branch whatever the associativity.
//
// Nodes are numbered as a heap: the root is node 0, and the children of node
// n are 2n+1 (left/lower) and 2n+2 (right/upper). A node bit of 0 points to
// the left half.
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int DEF_WAYS   = 4;
    localparam int DEF_ADDR_W = 26;
    localparam int DEF_SET_W  = 9;
    localparam int DEF_LINE_W = 4;
    localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_SET_W - DEF_LINE_W;

    typedef struct packed {
        logic                 valid;
        logic [DEF_TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic {
        ST_SWEEP,
        ST_READY
    } init_state_t;

    // Walk the touched way's path and make every node on it point away.
    function automatic logic [6:0] plru_touch(input logic [6:0] st,
                                              input logic [2:0] way_al,
                                              input int         levels);
        logic [6:0] r;
        logic [2:0] node;
        logic       b;
        r    = st;
        node = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < levels) begin
                b       = way_al[2-i];
                r[node] = ~b;
                node    = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
            end
        end
        return r;
    endfunction

    // Follow the node bits down from the root; the result is MSB-aligned.
    function automatic logic [2:0] plru_victim(input logic [6:0] st,
                                               input int         levels);
        logic [2:0] v;
        logic [2:0] node;
        logic       b;
        v    = '0;
        node = '0;
        for (int i = 0; i < 3; i++) begin
            if (i < levels) begin
                b      = st[node];
                v[2-i] = b;
                node   = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/cache_tag_array_if.sv
// ---------------------------------------------------------------------------
// cache_tag_array_if
// Command / result bundle between the cache controller (master) and the tag
// store (slave).
//   target_address           : shared address for lookup, fill and invalidate
//   in_lookup_valid          : lookup request
//   do_write / do_invalidate : fill / invalidate way in_way_index
//   in_way_index             : way for fill, invalidate and tag readback
//   in_ready                 : commands are accepted (low during init sweep)
//   out_valid                : lookup result valid
//   out_fault                : miss
//   out_way_index            : hit way
//   out_victim_index         : replacement way
//   out_addr_at_in_way_index : stored tag of the way given by in_way_index
// ---------------------------------------------------------------------------
interface cache_tag_array_if
    import cache_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SET_W  = DEF_SET_W,
    parameter int LINE_W = DEF_LINE_W
);
    localparam int TAG_W = ADDR_W - SET_W - LINE_W;
    localparam int WAY_W = $clog2(WAYS);

    logic [ADDR_W-1:0] target_address;
    logic              in_lookup_valid;
    logic              do_write;
    logic              do_invalidate;
    logic [WAY_W-1:0]  in_way_index;
    logic              in_ready;
    logic              out_valid;
    logic              out_fault;
    logic [WAY_W-1:0]  out_way_index;
    logic [WAY_W-1:0]  out_victim_index;
    logic [TAG_W-1:0]  out_addr_at_in_way_index;

    modport master (
        output target_address, in_lookup_valid, do_write, do_invalidate, in_way_index,
        input  in_ready, out_valid, out_fault, out_way_index, out_victim_index,
               out_addr_at_in_way_index
    );

    modport slave (
        input  target_address, in_lookup_valid, do_write, do_invalidate, in_way_index,
        output in_ready, out_valid, out_fault, out_way_index, out_victim_index,
               out_addr_at_in_way_index
    );
endinterface

// File: rtl/cache_tag_array_ram.sv
// ---------------------------------------------------------------------------
// cache_tag_ram
// Simple dual-port inferred RAM with a synchronous read.
//   main_clk      : clock
//   we/waddr/wdata: write port
//   raddr/rdata   : read port; rdata is registered
// On a read of the address being written in the same cycle, rdata returns the
// old contents. The tag array covers that case with its own bypass.
// ---------------------------------------------------------------------------
module cache_tag_ram #(
    parameter int DEPTH_W = 9,
    parameter int DATA_W  = 14
) (
    input  logic               main_clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_W];

    always_ff @(posedge main_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/cache_tag_array.sv
// ---------------------------------------------------------------------------
// cache_tag_array
// N-way set-associative tag store. It gives a hit/miss answer one cycle after
// a lookup and proposes a replacement victim for the looked-up set.
//   main_clk   : clock
//   main_rst_n : asynchronous active-low reset
//   bus        : cache_tag_array_if.slave (commands and lookup results)
// Replacement policy:
//   CACHE_TAG_PLRU_EN defined   -> per-set tree pseudo-LRU
//   CACHE_TAG_PLRU_EN undefined -> global round-robin counter, advanced by fills
// ---------------------------------------------------------------------------
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int WAYS   = DEF_WAYS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SET_W  = DEF_SET_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input logic              main_clk,
    input logic              main_rst_n,
    cache_tag_array_if.slave bus
);
    localparam int TAG_W = ADDR_W - SET_W - LINE_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 2**SET_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } entry_t;

    init_state_t      state_q, state_d;
    logic [SET_W-1:0] sweep_q;
    logic             ready, sweeping;

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) state_q <= ST_SWEEP;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_SWEEP && sweep_q == '1) state_d = ST_READY;
    end

    always_comb begin
        ready    = (state_q == ST_READY);
        sweeping = (state_q == ST_SWEEP);
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n)   sweep_q <= '0;
        else if (sweeping) sweep_q <= sweep_q + SET_W'(1);
    end

    logic [SET_W-1:0] cmd_set;
    logic [TAG_W-1:0] cmd_tag;
    logic             wr_acc, inv_acc, lkp_acc, unused_addr;
    entry_t           wr_entry;

    assign cmd_set     = bus.target_address[LINE_W+SET_W-1:LINE_W];
    assign cmd_tag     = bus.target_address[ADDR_W-1:LINE_W+SET_W];
    assign unused_addr = ^bus.target_address[LINE_W-1:0];
    assign wr_acc      = ready & bus.do_write;
    // A fill has priority over an invalidate issued in the same cycle.
    assign inv_acc     = ready & bus.do_invalidate & ~bus.do_write;
    assign lkp_acc     = ready & bus.in_lookup_valid;
    assign wr_entry    = '{valid: wr_acc, tag: cmd_tag};

    logic [WAYS-1:0]  ram_we;
    logic [SET_W-1:0] ram_waddr;
    entry_t           ram_wdata;
    entry_t           rd_entry [WAYS];

    // The init sweep clears every way of one set per cycle.
    always_comb begin
        ram_waddr = sweeping ? sweep_q : cmd_set;
        ram_wdata = sweeping ? '0 : wr_entry;
        for (int w = 0; w < WAYS; w++) begin
            ram_we[w] = sweeping | ((wr_acc | inv_acc) && bus.in_way_index == WAY_W'(w));
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_tag_ram #(.DEPTH_W(SET_W), .DATA_W(TAG_W + 1)) u_ram (
            .main_clk (main_clk),
            .we       (ram_we[w]),
            .waddr    (ram_waddr),
            .wdata    (ram_wdata),
            .raddr    (cmd_set),
            .rdata    (rd_entry[w])
        );
    end

    logic             lkp_valid_q, byp_valid_q;
    logic [SET_W-1:0] lkp_set_q;
    logic [TAG_W-1:0] lkp_tag_q;
    logic [WAY_W-1:0] lkp_sel_q, byp_way_q;
    entry_t           byp_entry_q;

    // A fill or invalidate in the same cycle as a lookup is captured so the
    // compare sees the new contents rather than the stale RAM read.
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            lkp_valid_q <= 1'b0;
            byp_valid_q <= 1'b0;
            lkp_set_q   <= '0;
            lkp_tag_q   <= '0;
            lkp_sel_q   <= '0;
            byp_way_q   <= '0;
            byp_entry_q <= '0;
        end else begin
            lkp_valid_q <= lkp_acc;
            byp_valid_q <= lkp_acc & (wr_acc | inv_acc);
            if (lkp_acc) begin
                lkp_set_q   <= cmd_set;
                lkp_tag_q   <= cmd_tag;
                lkp_sel_q   <= bus.in_way_index;
                byp_way_q   <= bus.in_way_index;
                byp_entry_q <= wr_entry;
            end
        end
    end

    entry_t           cmp_entry [WAYS];
    logic [WAYS-1:0]  hit_vec, valid_vec;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way, inv_way, policy_way, victim_way;
    logic [TAG_W-1:0] rb_tag;

    always_comb begin
        hit_vec   = '0;
        valid_vec = '0;
        hit_way   = '0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            cmp_entry[w] = (byp_valid_q && byp_way_q == WAY_W'(w)) ? byp_entry_q : rd_entry[w];
            valid_vec[w] = cmp_entry[w].valid;
            hit_vec[w]   = cmp_entry[w].valid && cmp_entry[w].tag == lkp_tag_q;
        end
        // Descending scans leave the lowest matching index.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])    hit_way = WAY_W'(w);
            if (!valid_vec[w]) inv_way = WAY_W'(w);
        end
        hit_any    = |hit_vec;
        victim_way = (&valid_vec) ? policy_way : inv_way;
        rb_tag     = cmp_entry[lkp_sel_q].tag;
    end

`ifdef CACHE_TAG_PLRU_EN
    logic [WAYS-2:0] plru_q [SETS];
    logic [6:0]      hit_st, hit_new, fill_st, fill_new;
    logic [2:0]      hit_way_al, fill_way_al, vic_al;
    logic            hit_touch, unused_plru;

    assign hit_touch   = lkp_valid_q & hit_any;
    assign unused_plru = ^{hit_new, fill_new, vic_al};

    // A hit touch and a fill touch to the same set at the same edge are
    // chained: hit first (older lookup), then the fill on top of it.
    always_comb begin
        hit_st      = '0;
        fill_st     = '0;
        hit_way_al  = '0;
        fill_way_al = '0;
        hit_st[WAYS-2:0]       = plru_q[lkp_set_q];
        hit_way_al[2 -: WAY_W] = hit_way;
        hit_new                = plru_touch(hit_st, hit_way_al, WAY_W);
        fill_st[WAYS-2:0]      = (hit_touch && lkp_set_q == cmd_set) ? hit_new[WAYS-2:0]
                                                                     : plru_q[cmd_set];
        fill_way_al[2 -: WAY_W] = bus.in_way_index;
        fill_new                = plru_touch(fill_st, fill_way_al, WAY_W);
        vic_al                  = plru_victim(hit_st, WAY_W);
        policy_way              = vic_al[2 -: WAY_W];
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            if (hit_touch) plru_q[lkp_set_q] <= hit_new[WAYS-2:0];
            if (wr_acc)    plru_q[cmd_set]   <= fill_new[WAYS-2:0];
        end
    end
`else
    logic [WAY_W-1:0] rr_q;
    logic             unused_rr;

    assign unused_rr  = ^lkp_set_q;
    assign policy_way = rr_q;

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n)  rr_q <= '0;
        else if (wr_acc)  rr_q <= rr_q + WAY_W'(1);
    end
`endif

    // When no lookup result is pending, the outputs hold the last result.
    logic             fault_q;
    logic [WAY_W-1:0] way_q, vic_q;
    logic [TAG_W-1:0] rb_q;

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            fault_q <= 1'b0;
            way_q   <= '0;
            vic_q   <= '0;
            rb_q    <= '0;
        end else if (lkp_valid_q) begin
            fault_q <= ~hit_any;
            way_q   <= hit_way;
            vic_q   <= victim_way;
            rb_q    <= rb_tag;
        end
    end

    assign bus.in_ready                 = ready;
    assign bus.out_valid                = lkp_valid_q;
    assign bus.out_fault                = lkp_valid_q ? ~hit_any   : fault_q;
    assign bus.out_way_index            = lkp_valid_q ? hit_way    : way_q;
    assign bus.out_victim_index         = lkp_valid_q ? victim_way : vic_q;
    assign bus.out_addr_at_in_way_index = lkp_valid_q ? rb_tag     : rb_q;
endmodule

// File: doc/cache_tag_array.md
# cache_tag_array

Parametrised N-way set-associative tag store for the data cache. It holds the tag and valid bit for each way of each set. It answers a hit/miss lookup one cycle after the address is presented, and proposes a replacement victim for every lookup. It sits between the cache controller and the line data RAMs and replaces the fixed 4-way, valid-less tag lookup with a resettable, replacement-aware block.

## Interface
- `WAYS`, 4: associativity; power of two, 2..8.
- `ADDR_W`, 26: physical address width.
- `SET_W`, 9: set index bits, taken from `target_address[LINE_W+SET_W-1:LINE_W]`.
- `LINE_W`, 4: line offset bits; ignored by this block.
- Derived: `TAG_W = ADDR_W-SET_W-LINE_W` (13 by default) and `WAY_W = $clog2(WAYS)`.

Ports:
- `main_clk` in 1: sole clock.
- `main_rst_n` in 1: asynchronous, active-low reset.
- `target_address` in ADDR_W: shared address for lookup, fill and invalidate.
- `in_lookup_valid` in 1: perform a lookup this cycle.
- `do_write` in 1: fill; writes the tag of `target_address` into way `in_way_index` and sets it valid.
- `do_invalidate` in 1: clears valid of way `in_way_index` in the addressed set.
- `in_way_index` in WAY_W: way targeted by fill, invalidate and tag readback.
- `in_ready` out 1: high when commands are accepted; low during the init sweep.
- `out_valid` out 1: lookup result valid.
- `out_fault` out 1: miss.
- `out_way_index` out WAY_W: hit way.
- `out_victim_index` out WAY_W: replacement way for the looked-up set.
- `out_addr_at_in_way_index` out TAG_W: stored tag of the way given by `in_way_index`, sampled with the lookup.

## Operation
- **Init sweep.**
  - After reset release, a counter walks sets 0..2^SET_W-1, one per cycle, writing valid=0 into every way.
  - `in_ready` is 0 throughout the sweep, and all commands are ignored.
- **Command acceptance.** Commands are accepted only while `in_ready` is 1.
- **Lookup, cycle N.** `in_lookup_valid` reads all ways of the set.
- **Lookup result, cycle N+1.**
  - `out_valid` is 1.
  - Hit = valid and stored tag equals the registered tag.
  - `out_fault` = no hit.
  - `out_way_index` = lowest-index hitting way, or 0 on a miss.
- **Victim selection.** The victim is the lowest-index invalid way. If every way is valid, the victim comes from the replacement policy (see Configuration).
- **Write-first bypass.** If `do_write` or `do_invalidate` coincides with a lookup, the targeted way's compare uses the new tag/valid, not the RAM read data.
- **Simultaneous fill and invalidate.** `do_write` and `do_invalidate` in the same cycle: `do_write` wins.
- **Replacement touch.** A fill touches its written way. A lookup hit touches the hit way at N+1, using the registered set index. Same-set back-to-back touches are forwarded, with no lost update.

## Timing
- Lookup latency is exactly 1 cycle, and a new lookup is accepted every cycle.
- Fill/invalidate at edge N is visible to a lookup presented at edge N (via bypass) or later.
- `in_ready` rises 2^SET_W cycles after the first clock edge following reset release (512 by default).
- Reset values:
  - `in_ready`, `out_valid`, `out_fault`: 0.
  - `out_way_index`, `out_victim_index`, `out_addr_at_in_way_index`: 0.
  - Sweep counter: 0.
  - Replacement state: 0.
- Reset asserted mid-sweep aborts the sweep. It restarts from set 0 after release.
- When no lookup is issued, `out_valid` is 0 next cycle, and the other outputs hold their last values.

## Configuration
- `CACHE_TAG_PLRU_EN` defined:
  - Per-set tree pseudo-LRU, WAYS-1 bits per set, held in flops with async reset to 0.
  - A touch sets each node on the path to point away from the touched way.
  - The victim follows the node bits from the root; 0 means the left/lower half.
- `CACHE_TAG_PLRU_EN` undefined:
  - A single global round-robin counter of WAY_W bits, reset 0, incremented on each accepted `do_write`. It is the all-valid victim.
  - No per-set state and no touch on hits.

## Structure
- `cache_pkg` holds:
  - the `tag_entry_t` struct {valid, tag};
  - the default width constants;
  - the PLRU touch and victim functions.
- One sub-module, `cache_tag_ram`: simple dual-port inferred RAM, 2^SET_W × (TAG_W+1), synchronous read, instantiated once per way in a generate loop.

## Test plan
- **Init sweep length.** Release reset and count cycles to `in_ready` -> 512. A lookup of 0x0000000 at that point -> `out_fault`=1, `out_victim_index`=0.
- **Fill then hit.** Fill 0x1234560 into way 2; look it up next cycle -> `out_fault`=0, `out_way_index`=2, `out_addr_at_in_way_index` (with `in_way_index`=2) = 0x91A.
- **Same-cycle fill and lookup.** Fill 0x0ABCDE0 into way 1 with a lookup in the same cycle -> hit on way 1 at N+1.
- **PLRU victim.** With PLRU enabled: fill set 5 ways 0..3 with distinct tags, then hit way 0, then way 2 -> `out_victim_index`=1. Without the macro, the victim after four fills is 0.
- **Invalidate.** Invalidate way 2 of the full set 5, then look up its former tag -> `out_fault`=1, `out_victim_index`=2.
- **Reset mid-sweep.** Assert `main_rst_n`=0 at sweep cycle 100 -> outputs 0 immediately; after release, `in_ready` rises after 512 cycles.
